// File: rtl/reorder_buffer_param.sv
// In-order-retire reorder buffer: circular queue indexed by ROB tag, tagged completion ports,
// up to RETIRE_W retirements per cycle. Define ROB_FLUSH_EN to add the i_flush input.
module reorder_buffer_param #(
   parameter int DEPTH     = 64,
   parameter int IDX_W     = 6,
   parameter int PREG_W    = 6,
   parameter int CPL_PORTS = 4,
   parameter int RETIRE_W  = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
`ifdef ROB_FLUSH_EN
   input  logic                       i_flush,
`endif
   input  logic                       i_disp_valid,
   output logic                       o_disp_ready,
   input  logic                       i_disp_has_dest,
   input  logic [4:0]                 i_disp_arch_rd,
   input  logic [PREG_W-1:0]          i_disp_dest_preg,
   input  logic [PREG_W-1:0]          i_disp_old_preg,
   input  logic                       i_disp_is_store,
   input  logic [31:0]                i_disp_pc,
   output logic [IDX_W-1:0]           o_disp_tag,
   input  logic [CPL_PORTS-1:0]       i_cpl_valid,
   input  logic [CPL_PORTS*IDX_W-1:0] i_cpl_tag,
   input  logic [CPL_PORTS*32-1:0]    i_cpl_data,
   output logic [RETIRE_W-1:0]        o_ret_valid,
   output logic [RETIRE_W*5-1:0]      o_ret_arch_rd,
   output logic [RETIRE_W*PREG_W-1:0] o_ret_dest_preg,
   output logic [RETIRE_W*PREG_W-1:0] o_ret_old_preg,
   output logic [RETIRE_W*32-1:0]     o_ret_data,
   output logic [RETIRE_W*32-1:0]     o_ret_pc,
   output logic [RETIRE_W-1:0]        o_ret_has_dest,
   output logic [RETIRE_W-1:0]        o_ret_is_store,
   output logic [IDX_W:0]             o_count,
   output logic                       o_empty,
   output logic                       o_full
);

   localparam logic [IDX_W:0] CNT_ONE   = (IDX_W+1)'(1);
   localparam logic [IDX_W:0] CNT_DEPTH = (IDX_W+1)'(DEPTH);

   logic [IDX_W-1:0]  r_head;
   logic [IDX_W-1:0]  r_tail;
   logic [IDX_W:0]    r_count;
   logic [DEPTH-1:0]  r_valid;
   logic [DEPTH-1:0]  r_cmpl;
   logic [DEPTH-1:0]  r_has_dest;
   logic [DEPTH-1:0]  r_is_store;
   logic [4:0]        r_arch_rd   [DEPTH];
   logic [PREG_W-1:0] r_dest_preg [DEPTH];
   logic [PREG_W-1:0] r_old_preg  [DEPTH];
   logic [31:0]       r_pc        [DEPTH];
   logic [31:0]       r_data      [DEPTH];

   logic [RETIRE_W-1:0]        r_ret_valid;
   logic [RETIRE_W*5-1:0]      r_ret_arch_rd;
   logic [RETIRE_W*PREG_W-1:0] r_ret_dest_preg;
   logic [RETIRE_W*PREG_W-1:0] r_ret_old_preg;
   logic [RETIRE_W*32-1:0]     r_ret_data;
   logic [RETIRE_W*32-1:0]     r_ret_pc;
   logic [RETIRE_W-1:0]        r_ret_has_dest;
   logic [RETIRE_W-1:0]        r_ret_is_store;

   logic                w_flush;
   logic                w_disp_fire;
   logic [IDX_W-1:0]    w_cpl_tag [CPL_PORTS];
   logic [IDX_W-1:0]    w_ret_idx [RETIRE_W];
   logic [RETIRE_W-1:0] w_ret_lane;
   logic [IDX_W:0]      w_ret_n;
   logic                w_stop;

`ifdef ROB_FLUSH_EN
   assign w_flush = i_flush;
`else
   assign w_flush = 1'b0;
`endif

   // Slot availability comes from the registered count only; retirement this cycle does not help.
   assign o_disp_ready = (r_count != CNT_DEPTH) && !w_flush;
   assign w_disp_fire  = i_disp_valid && o_disp_ready;
   assign o_disp_tag   = r_tail;

   always_comb begin
      for (int k = 0; k < CPL_PORTS; k++) begin
         w_cpl_tag[k] = i_cpl_tag[k*IDX_W +: IDX_W];
      end
   end

   // Longest valid&&complete prefix from head; a store may only take lane 0.
   always_comb begin
      w_ret_lane = '0;
      w_ret_n    = '0;
      w_stop     = 1'b0;
      for (int j = 0; j < RETIRE_W; j++) begin
         w_ret_idx[j] = r_head + IDX_W'(j);
         if (!w_stop) begin
            if (!(r_valid[w_ret_idx[j]] && r_cmpl[w_ret_idx[j]]) ||
                ((j != 0) && r_is_store[w_ret_idx[j]])) begin
               w_stop = 1'b1;
            end else begin
               w_ret_lane[j] = 1'b1;
               w_ret_n       = w_ret_n + CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || w_flush) begin
         r_head          <= '0;
         r_tail          <= '0;
         r_count         <= '0;
         r_valid         <= '0;
         r_cmpl          <= '0;
         r_ret_valid     <= '0;
         r_ret_arch_rd   <= '0;
         r_ret_dest_preg <= '0;
         r_ret_old_preg  <= '0;
         r_ret_data      <= '0;
         r_ret_pc        <= '0;
         r_ret_has_dest  <= '0;
         r_ret_is_store  <= '0;
      end else begin
         for (int k = 0; k < CPL_PORTS; k++) begin
            if (i_cpl_valid[k] && r_valid[w_cpl_tag[k]]) begin
               r_cmpl[w_cpl_tag[k]] <= 1'b1;
            end
         end
         for (int j = 0; j < RETIRE_W; j++) begin
            if (w_ret_lane[j]) begin
               r_valid[w_ret_idx[j]] <= 1'b0;
               r_cmpl[w_ret_idx[j]]  <= 1'b0;
            end
            r_ret_valid[j]                 <= w_ret_lane[j];
            r_ret_has_dest[j]              <= w_ret_lane[j] & r_has_dest[w_ret_idx[j]];
            r_ret_is_store[j]              <= w_ret_lane[j] & r_is_store[w_ret_idx[j]];
            r_ret_arch_rd[j*5 +: 5]        <= w_ret_lane[j] ? r_arch_rd[w_ret_idx[j]] : '0;
            r_ret_dest_preg[j*PREG_W +: PREG_W] <= w_ret_lane[j] ? r_dest_preg[w_ret_idx[j]] : '0;
            r_ret_old_preg[j*PREG_W +: PREG_W]  <= w_ret_lane[j] ? r_old_preg[w_ret_idx[j]] : '0;
            r_ret_data[j*32 +: 32]         <= w_ret_lane[j] ? r_data[w_ret_idx[j]] : '0;
            r_ret_pc[j*32 +: 32]           <= w_ret_lane[j] ? r_pc[w_ret_idx[j]] : '0;
         end
         if (w_disp_fire) begin
            r_valid[r_tail] <= 1'b1;
            r_cmpl[r_tail]  <= 1'b0;
            r_tail          <= r_tail + IDX_W'(1);
         end
         r_head  <= r_head + w_ret_n[IDX_W-1:0];
         r_count <= r_count + (w_disp_fire ? CNT_ONE : '0) - w_ret_n;
      end
   end

   // Payload storage needs no reset: valid bits gate every use.
   always_ff @(posedge i_clk) begin
      if (w_disp_fire) begin
         r_has_dest[r_tail]  <= i_disp_has_dest;
         r_is_store[r_tail]  <= i_disp_is_store;
         r_arch_rd[r_tail]   <= i_disp_arch_rd;
         r_dest_preg[r_tail] <= i_disp_dest_preg;
         r_old_preg[r_tail]  <= i_disp_old_preg;
         r_pc[r_tail]        <= i_disp_pc;
      end
      for (int k = 0; k < CPL_PORTS; k++) begin
         if (!i_rst && !w_flush && i_cpl_valid[k] && r_valid[w_cpl_tag[k]]) begin
            r_data[w_cpl_tag[k]] <= i_cpl_data[k*32 +: 32];
         end
      end
   end

   assign o_ret_valid     = r_ret_valid;
   assign o_ret_arch_rd   = r_ret_arch_rd;
   assign o_ret_dest_preg = r_ret_dest_preg;
   assign o_ret_old_preg  = r_ret_old_preg;
   assign o_ret_data      = r_ret_data;
   assign o_ret_pc        = r_ret_pc;
   assign o_ret_has_dest  = r_ret_has_dest;
   assign o_ret_is_store  = r_ret_is_store;
   assign o_count         = r_count;
   assign o_empty         = (r_count == '0);
   assign o_full          = (r_count == CNT_DEPTH);

endmodule
